// File: rtl/argmax_unit.sv
// Sequential arg-max over DIM signed elements: one compare per clock, done at start+DIM, ties go to the lowest index.
// Optional macro ARGMAX_MAXVAL_EN adds a max_val output holding the winning element.
module argmax_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int DIM        = 10,
  parameter int IDXW       = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] vec [0:DIM-1],
  output logic        [IDXW-1:0]       idx,
  output logic                         done,
  output logic                         busy
`ifdef ARGMAX_MAXVAL_EN
  ,
  output logic signed [DATA_WIDTH-1:0] max_val
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

  localparam logic [IDXW-1:0] LAST = IDXW'(DIM - 1);

  state_t state, state_nxt;

  logic signed [DATA_WIDTH-1:0] snap [0:DIM-1];
  logic signed [DATA_WIDTH-1:0] best_val;
  logic        [IDXW-1:0]       best_idx;
  logic        [IDXW-1:0]       cnt;
  logic                         take;

  // Strictly greater keeps the earliest index on ties.
  assign take = (snap[cnt] > best_val);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (DIM == 1) ? FINISH : SCAN;
        end
      end
      SCAN: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          state_nxt = FINISH;
        end
      end
      FINISH: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // idx is loaded on the edge into FINISH so it is already valid while done is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DIM; k++) begin
        snap[k] <= '0;
      end
      best_val <= '0;
      best_idx <= '0;
      cnt      <= '0;
      idx      <= '0;
`ifdef ARGMAX_MAXVAL_EN
      max_val  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snap     <= vec;
            best_val <= vec[0];
            best_idx <= '0;
            cnt      <= IDXW'(1);
            if (DIM == 1) begin
              idx <= '0;
`ifdef ARGMAX_MAXVAL_EN
              max_val <= vec[0];
`endif
            end
          end
        end
        SCAN: begin
          if (take) begin
            best_val <= snap[cnt];
            best_idx <= cnt;
          end
          if (cnt == LAST) begin
            idx <= take ? cnt : best_idx;
`ifdef ARGMAX_MAXVAL_EN
            max_val <= take ? snap[cnt] : best_val;
`endif
          end else begin
            cnt <= cnt + IDXW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_unit.sv
// Randomized self-checking bench for argmax_unit against a plain-loop arg-max model.
module tb_argmax_unit;
  localparam int DW   = 16;
  localparam int DIM  = 10;
  localparam int IDXW = 4;

  typedef logic signed [DW-1:0] vec_t [0:DIM-1];

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  vec_t            vec;
  logic [IDXW-1:0] idx;
  logic            done;
  logic            busy;
`ifdef ARGMAX_MAXVAL_EN
  logic signed [DW-1:0] max_val;
`endif

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  argmax_unit #(.DATA_WIDTH(DW), .DIM(DIM), .IDXW(IDXW)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .vec   (vec),
    .idx   (idx),
    .done  (done),
    .busy  (busy)
`ifdef ARGMAX_MAXVAL_EN
    ,
    .max_val(max_val)
`endif
  );

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int model_idx(input vec_t v);
    int best = 0;
    for (int k = 1; k < DIM; k++) if (v[k] > v[best]) best = k;
    return best;
  endfunction

  function automatic logic signed [DW-1:0] rnd16();
    logic [31:0] r;
    r = $urandom;
    return r[DW-1:0];
  endfunction

  // vec is scrambled every cycle after the start cycle; restart_at>0 pulses an extra start.
  task automatic run_scan(input vec_t v, input int restart_at);
    int exp_i;
    int cyc;
    int dc0;
    exp_i = model_idx(v);
    @(negedge clk);
    vec   = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    dc0   = done_cnt;
    while (!done && cyc < 40) begin
      for (int k = 0; k < DIM; k++) vec[k] = rnd16();
      start = (cyc == restart_at);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("latency", cyc, DIM);
    check("idx", idx, exp_i);
    check("busy_at_done", busy, 1);
`ifdef ARGMAX_MAXVAL_EN
    check("max_val", max_val, v[exp_i]);
`endif
    @(negedge clk);
    check("done_pulse_width", done, 0);
    check("busy_after_done", busy, 0);
    repeat (3) @(negedge clk);
    check("done_count", done_cnt - dc0, 1);
    check("idx_held", idx, exp_i);
  endtask

  initial begin
    vec_t v;
    int   dc0;
    reset = 1'b1;
    start = 1'b0;
    for (int k = 0; k < DIM; k++) vec[k] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("rst_idx", idx, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
    end

    v = '{16'sd5, -16'sd3, 16'sd12, 16'sd7, 16'sd0, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd11};
    run_scan(v, 0);
    check("example_idx", idx, 2);

    v = '{-16'sd100, -16'sd7, -16'sd50, -16'sd7, -16'sd8, -16'sd200, -16'sd9, -16'sd10, -16'sd11, -16'sd12};
    run_scan(v, 0);
    check("neg_tie_idx", idx, 1);

    for (int k = 0; k < DIM; k++) v[k] = 16'sh7FFF;
    run_scan(v, 0);
    check("all_max_idx", idx, 0);

    for (int k = 0; k < DIM; k++) v[k] = 16'sh8000;
    v[9] = 16'sh7FFF;
    run_scan(v, 0);
    check("last_max_idx", idx, 9);

    v = '{16'sd5, -16'sd3, 16'sd12, 16'sd7, 16'sd0, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd11};
    run_scan(v, 3);
    check("restart_ignored_idx", idx, 2);

    // Reset in the middle of a scan: no done, idx cleared.
    for (int k = 0; k < DIM; k++) v[k] = 16'sh8000;
    v[7] = 16'sd1;
    @(negedge clk);
    vec   = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dc0   = done_cnt;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("abort_no_done", done_cnt - dc0, 0);
    check("abort_idx", idx, 0);
    check("abort_busy", busy, 0);

    for (int k = 0; k < DIM; k++) v[k] = -16'sd5;
    v[4] = 16'sd300;
    run_scan(v, 0);
    check("post_abort_idx", idx, 4);

    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < DIM; k++) begin
        if (n % 3 == 0) v[k] = DW'($signed($urandom_range(0, 4)) - 2);
        else            v[k] = rnd16();
      end
      run_scan(v, (n % 4 == 1) ? int'($urandom_range(1, 8)) : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
